// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx round-robin arbiter.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_START_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

  // Frame settings latched at grant and held for uart_tx until the next grant.
  typedef struct packed {
    logic [7:0] data;
    logic       parity_en;
    logic       even_parity;
  } tx_cfg_t;

  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after i_rr_ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_winner,
  output logic                       o_any_valid
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NUM_REQ);

  logic [NUM_REQ-1:0][IDXW-1:0] w_idx;
  logic [NUM_REQ-1:0]           w_rot;

  // w_rot[k] is the requester k positions after the pointer, modulo NUM_REQ.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_rot
    logic [IDXW:0] w_sum;
    assign w_sum    = {1'b0, i_rr_ptr} + (IDXW+1)'(k);
    assign w_idx[k] = (w_sum >= NREQ_W) ? IDXW'(w_sum - NREQ_W) : w_sum[IDXW-1:0];
    assign w_rot[k] = i_req_valid[w_idx[k]];
  end

  always_comb begin
    o_grant     = '0;
    o_winner    = '0;
    o_any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_winner    = w_idx[k];
        o_any_valid = 1'b1;
      end
    end
    if (o_any_valid) o_grant[o_winner] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers: grant, start pulse, busy tracking.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ-1:0][7:0]      i_req_data,
  input  logic [NUM_REQ-1:0]           i_req_parity_en,
  input  logic [NUM_REQ-1:0]           i_req_even_parity,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_tx_start,
  output logic [7:0]                   o_data_in,
  output logic                         o_parity_en,
  output logic                         o_even_parity,
  input  logic                         i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
  output logic                         o_frame_done,
  output logic                         o_timeout_err
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = cnt_width(START_TIMEOUT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(START_TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_REQ - 1);

  arb_state_e        r_state;
  logic [IDXW-1:0]   r_rr_ptr;
  logic [IDXW-1:0]   r_grant_id;
  logic [CNTW-1:0]   r_cnt;
  tx_cfg_t           r_cfg;
  logic              r_tx_start;
  logic              r_frame_done;
  logic              r_timeout_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDXW-1:0]    w_winner;
  logic               w_any_valid;
  logic               w_can_grant;
  logic               w_xfer;
  tx_cfg_t            w_sel_cfg;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req_valid (i_req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  // A busy transmitter in IDLE is a foreign or residual frame: hold off all grants.
  assign w_can_grant = (r_state == IDLE) && !i_tx_busy;
  assign o_req_ready = w_can_grant ? w_grant : '0;
  assign w_xfer      = |(i_req_valid & o_req_ready);
  assign w_sel_cfg   = {i_req_data[w_winner], i_req_parity_en[w_winner],
                        i_req_even_parity[w_winner]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_cnt         <= '0;
      r_cfg         <= '0;
      r_tx_start    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_cfg      <= w_sel_cfg;
            r_grant_id <= w_winner;
            r_rr_ptr   <= (w_winner == IDX_LAST) ? '0 : w_winner + 1'b1;
            r_tx_start <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == CNT_LAST) begin
            // Pointer already sits past the dropped requester; no retry.
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_start    = r_tx_start;
  assign o_data_in     = r_cfg.data;
  assign o_parity_en   = r_cfg.parity_en;
  assign o_even_parity = r_cfg.even_parity;
  assign o_grant_id    = r_grant_id;
  assign o_frame_done  = r_frame_done;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx stub on the serial side.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int BIT_CLKS = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid, req_parity_en, req_even_parity, req_ready;
  logic [N-1:0][7:0]    req_data;
  logic                 tx_start, parity_en, even_parity, frame_done, timeout_err;
  logic                 tx_busy;
  logic [7:0]           data_in;
  logic [1:0]           grant_id;

  logic stub_busy, force_busy, stub_en, tx_line;
  int   checks, failures;
  int   cyc = 0;
  int   n_start, n_done, n_to, n_viol;
  int   start_cyc, done_cyc, to_cyc, b2b_gap;
  int   gid_q[$];
  logic [7:0]  dat_q[$];
  logic [10:0] cap_frame;
  int   cap_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign tx_busy = stub_busy | force_busy;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(8)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_req_valid       (req_valid),
    .i_req_data        (req_data),
    .i_req_parity_en   (req_parity_en),
    .i_req_even_parity (req_even_parity),
    .o_req_ready       (req_ready),
    .o_tx_start        (tx_start),
    .o_data_in         (data_in),
    .o_parity_en       (parity_en),
    .o_even_parity     (even_parity),
    .i_tx_busy         (tx_busy),
    .o_grant_id        (grant_id),
    .o_frame_done      (frame_done),
    .o_timeout_err     (timeout_err)
  );

  // uart_tx stand-in: busy one cycle after start, LSB-first frame, BIT_CLKS per bit.
  initial begin : stub
    logic [10:0] fr, cap;
    int nb;
    logic pb;
    stub_busy = 1'b0;
    tx_line   = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start && stub_en) begin
        pb = even_parity ? ^data_in : ~(^data_in);
        fr = parity_en ? {1'b1, pb, data_in, 1'b0} : {2'b11, data_in, 1'b0};
        nb = parity_en ? 11 : 10;
        cap = '0;
        @(negedge clk);
        stub_busy = 1'b1;
        for (int i = 0; i < nb; i++) begin
          tx_line = fr[i];
          cap[i]  = tx_line;
          repeat (BIT_CLKS) @(negedge clk);
        end
        tx_line   = 1'b1;
        stub_busy = 1'b0;
        cap_frame = cap;
        cap_n     = nb;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (tx_start) begin
      n_start++;
      if (n_done > 0) b2b_gap = cyc - done_cyc;
      start_cyc = cyc;
      gid_q.push_back(int'(grant_id));
      dat_q.push_back(data_in);
      if (tx_busy) n_viol++;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (timeout_err) begin
      n_to++;
      to_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0: return n_start;
      1: return n_done;
      default: return n_to;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cnt_of(which) >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_parity_en = '0; req_even_parity = '0;
    force_busy = 1'b0;
    stub_en = 1'b1;
    for (int i = 0; i < 100 && stub_busy; i++) tick();
    repeat (2) tick();
    n_start = 0; n_done = 0; n_to = 0; n_viol = 0; b2b_gap = -1;
    gid_q.delete(); dat_q.delete();
    cap_n = 0; cap_frame = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (tx_start !== 1'b0)    begin failures++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
    checks++; if (data_in !== 8'h00)    begin failures++; $display("FAIL rst_data_in got=%h exp=00", data_in); end
    checks++; if (parity_en !== 1'b0)   begin failures++; $display("FAIL rst_parity_en got=%b exp=0", parity_en); end
    checks++; if (even_parity !== 1'b0) begin failures++; $display("FAIL rst_even_parity got=%b exp=0", even_parity); end
    checks++; if (req_ready !== 4'b0)   begin failures++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    checks++; if (grant_id !== 2'd0)    begin failures++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    checks++; if (frame_done !== 1'b0)  begin failures++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    req_data[0] = 8'hA5; req_parity_en = 4'b0001; req_even_parity = 4'b0001;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    wait_for(0, 1, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_start_wait got=timeout exp=tx_start"); end
    req_valid = '0;
    checks++; if (data_in !== 8'hA5)    begin failures++; $display("FAIL single_data got=%h exp=a5", data_in); end
    checks++; if (parity_en !== 1'b1 || even_parity !== 1'b1) begin
      failures++; $display("FAIL single_parity got=%b%b exp=11", parity_en, even_parity); end
    checks++; if (grant_id !== 2'd0)    begin failures++; $display("FAIL single_grant got=%0d exp=0", grant_id); end
    wait_for(1, 1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_done_wait got=timeout exp=frame_done"); end
    repeat (5) tick();
    checks++; if (n_start !== 1) begin failures++; $display("FAIL single_start_cnt got=%0d exp=1", n_start); end
    checks++; if (n_done !== 1)  begin failures++; $display("FAIL single_done_cnt got=%0d exp=1", n_done); end
    checks++; if (cap_n !== 11 || cap_frame !== 11'h54A) begin
      failures++; $display("FAIL single_frame got=%0d/%h exp=11/54a", cap_n, cap_frame); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_parity_en = 4'b1111; req_even_parity = 4'b1111;
    req_valid = 4'b1111;
    wait_for(0, 5, 400, ok);
    req_valid = '0;
    checks++; if (!ok) begin failures++; $display("FAIL rr_start_wait got=%0d exp=5", n_start); end
    checks++; if (b2b_gap !== 1) begin failures++; $display("FAIL rr_b2b_gap got=%0d exp=1", b2b_gap); end
    wait_for(1, 5, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_done_wait got=%0d exp=5", n_done); end
    checks++;
    if (gid_q.size() != 5) begin
      failures++; $display("FAIL rr_grant_cnt got=%0d exp=5", gid_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (gid_q[i] != exp_g[i] || dat_q[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL rr_order idx=%0d got=%0d/%h exp=%0d/%h", i, gid_q[i], dat_q[i], exp_g[i], exp_d[i]);
          break;
        end
      end
    end
    checks++; if (n_viol !== 0) begin failures++; $display("FAIL rr_start_while_busy got=%0d exp=0", n_viol); end
  endtask

  task automatic test_pointer();
    bit ok;
    do_reset();
    req_data = {8'h3C, 8'h00, 8'h21, 8'hC0};
    req_valid = 4'b0010;
    wait_for(0, 1, 20, ok);
    req_valid = '0;
    wait_for(1, 1, 100, ok);
    req_valid = 4'b1001;
    wait_for(0, 3, 200, ok);
    req_valid = '0;
    wait_for(1, 3, 200, ok);
    checks++;
    if (gid_q.size() != 3) begin
      failures++; $display("FAIL ptr_grant_cnt got=%0d exp=3", gid_q.size());
    end else if (gid_q[0] != 1 || gid_q[1] != 3 || gid_q[2] != 0) begin
      failures++; $display("FAIL ptr_order got=%0d,%0d,%0d exp=1,3,0", gid_q[0], gid_q[1], gid_q[2]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    stub_en = 1'b0;
    req_data = {8'h00, 8'h00, 8'h66, 8'h55};
    req_valid = 4'b0011;
    wait_for(0, 1, 20, ok);
    checks++; if (!ok || grant_id !== 2'd0) begin failures++; $display("FAIL to_first_grant got=%0d exp=0", grant_id); end
    wait_for(2, 1, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_wait got=timeout exp=timeout_err"); end
    checks++; if (to_cyc - start_cyc !== 9) begin failures++; $display("FAIL to_latency got=%0d exp=9", to_cyc - start_cyc); end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL to_idle_ready got=%b exp=0010", req_ready); end
    stub_en = 1'b1;
    tick();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", timeout_err); end
    wait_for(0, 2, 10, ok);
    req_valid = '0;
    checks++;
    if (gid_q.size() != 2) begin
      failures++; $display("FAIL to_next_cnt got=%0d exp=2", gid_q.size());
    end else if (gid_q[1] != 1 || dat_q[1] !== 8'h66) begin
      failures++; $display("FAIL to_next_grant got=%0d/%h exp=1/66", gid_q[1], dat_q[1]);
    end
    wait_for(1, 1, 100, ok);
    checks++; if (!ok || n_to !== 1) begin failures++; $display("FAIL to_recover got=done%0d/to%0d exp=1/1", n_done, n_to); end
  endtask

  task automatic test_reset_mid();
    bit ok, saw_ready;
    do_reset();
    req_data[2] = 8'h5A; req_parity_en = 4'b0100; req_even_parity = 4'b0100;
    req_valid = 4'b0100;
    wait_for(0, 1, 20, ok);
    repeat (6) tick();
    checks++; if (grant_id !== 2'd2 || data_in !== 8'h5A) begin
      failures++; $display("FAIL mid_pre got=%0d/%h exp=2/5a", grant_id, data_in); end
    force_busy = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++; if (data_in !== 8'h00 || parity_en !== 1'b0 || even_parity !== 1'b0) begin
      failures++; $display("FAIL mid_rst_cfg got=%h/%b/%b exp=00/0/0", data_in, parity_en, even_parity); end
    checks++; if (grant_id !== 2'd0 || tx_start !== 1'b0 || req_ready !== 4'b0) begin
      failures++; $display("FAIL mid_rst_ctl got=%0d/%b/%b exp=0/0/0000", grant_id, tx_start, req_ready); end
    checks++; if (frame_done !== 1'b0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL mid_rst_pulse got=%b/%b exp=0/0", frame_done, timeout_err); end
    tick();
    rst = 1'b0;
    n_start = 0; n_done = 0; gid_q.delete(); dat_q.delete();
    saw_ready = 1'b0;
    for (int i = 0; i < 60 && stub_busy; i++) begin
      tick();
      if (req_ready !== 4'b0) saw_ready = 1'b1;
    end
    repeat (3) begin
      tick();
      if (req_ready !== 4'b0) saw_ready = 1'b1;
    end
    checks++; if (saw_ready || n_start !== 0) begin
      failures++; $display("FAIL mid_hold got=ready%b/starts%0d exp=0/0", saw_ready, n_start); end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", n_done); end
    force_busy = 1'b0;
    wait_for(0, 1, 5, ok);
    req_valid = '0;
    checks++; if (!ok || grant_id !== 2'd2) begin
      failures++; $display("FAIL mid_regrant got=%0d ok=%b exp=2", grant_id, ok); end
    wait_for(1, 1, 100, ok);
  endtask

  task automatic test_parity_off();
    bit ok;
    do_reset();
    req_data = {8'h00, 8'hC3, 8'h0F, 8'h00};
    req_parity_en = 4'b0100; req_even_parity = 4'b0000;
    req_valid = 4'b0010;
    wait_for(0, 1, 20, ok);
    req_valid = '0;
    checks++; if (!ok || parity_en !== 1'b0 || grant_id !== 2'd1) begin
      failures++; $display("FAIL poff_cfg got=%b/%0d exp=0/1", parity_en, grant_id); end
    wait_for(1, 1, 100, ok);
    checks++; if (!ok || cap_n !== 10 || cap_frame !== 11'h21E) begin
      failures++; $display("FAIL poff_frame got=%0d/%h exp=10/21e", cap_n, cap_frame); end
    req_valid = 4'b0100;
    wait_for(0, 2, 20, ok);
    req_valid = '0;
    checks++; if (!ok || parity_en !== 1'b1 || even_parity !== 1'b0 || grant_id !== 2'd2) begin
      failures++; $display("FAIL pon_cfg got=%b%b/%0d exp=10/2", parity_en, even_parity, grant_id); end
    wait_for(1, 2, 100, ok);
    checks++; if (!ok || cap_n !== 11 || cap_frame !== 11'h786) begin
      failures++; $display("FAIL pon_frame got=%0d/%h exp=11/786", cap_n, cap_frame); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_parity_en = '0; req_even_parity = '0;
    force_busy = 1'b0; stub_en = 1'b1;
    n_start = 0; n_done = 0; n_to = 0; n_viol = 0;
    start_cyc = 0; done_cyc = 0; to_cyc = 0; b2b_gap = -1;
    cap_n = 0; cap_frame = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_pointer();
    test_timeout();
    test_reset_mid();
    test_parity_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `NUM_REQ` byte producers. Each producer offers a byte plus parity settings on a valid/ready handshake. The block grants one producer at a time, drives the `uart_tx` `tx_start`/`data_in`/`parity_en`/`even_parity` inputs, and tracks `tx_busy` until the frame completes. It sits between the producer logic and the single `uart_tx` instance.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `START_TIMEOUT`, 8 — cycles allowed after `tx_start` for `tx_busy` to rise.
- `clk` input 1 — single clock; all logic on posedge.
- `rst` input 1 — reset, asynchronous and active-high.
- `req_valid` input `NUM_REQ` — requester i offers a byte.
- `req_data` input `NUM_REQ`×8 — byte per requester.
- `req_parity_en` input `NUM_REQ` — parity enable per requester.
- `req_even_parity` input `NUM_REQ` — 1 = even parity, 0 = odd.
- `req_ready` output `NUM_REQ` — one-hot; transfer on `req_valid[i] & req_ready[i]`.
- `tx_start` output 1 — one-cycle start pulse to `uart_tx`.
- `data_in` output 8 — latched byte to `uart_tx`.
- `parity_en` output 1 — latched parity enable.
- `even_parity` output 1 — latched parity select.
- `tx_busy` input 1 — busy from `uart_tx`.
- `grant_id` output `$clog2(NUM_REQ)` — index of the current or last granted requester.
- `frame_done` output 1 — one-cycle pulse when `tx_busy` falls for the granted frame.
- `timeout_err` output 1 — one-cycle pulse when `tx_busy` fails to rise.

## Operation
- FSM states and transitions:
  - IDLE: if `tx_busy == 0` and any `req_valid` is high, go to START.
  - START: assert `tx_start`, then go to WAIT_BUSY.
  - WAIT_BUSY: if `tx_busy` is high, go to WAIT_DONE. If the counter reaches `START_TIMEOUT`, pulse `timeout_err` and go to IDLE.
  - WAIT_DONE: when `tx_busy` falls, pulse `frame_done` and go to IDLE.
- Arbitration is round-robin from pointer `rr_ptr`. The winner is the first valid requester at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - On grant: `rr_ptr` ← winner+1, wrapping `NUM_REQ-1` → 0.
  - The pointer also advances on timeout. The timed-out requester's byte is dropped, not retried.
- `req_ready` is combinational. It is nonzero only in IDLE with `tx_busy == 0`, and is one-hot on the winner.
- In the handshake cycle, `data_in`, `parity_en`, `even_parity` and `grant_id` are registered. They hold stable until the next grant.
- `req_valid` deasserting outside IDLE has no effect. No abort path exists.
- If `tx_busy` is high while in IDLE (a foreign or residual frame), no grant is issued.
- The timeout counter is 4 bits minimum. It clears on entry to WAIT_BUSY.

## Timing
- Reset values:
  - outputs: `tx_start`=0, `data_in`=8'h00, `parity_en`=0, `even_parity`=0, `req_ready`=0, `grant_id`=0, `frame_done`=0, `timeout_err`=0
  - internal: `rr_ptr`=0, state IDLE
- Reset mid-frame returns the FSM to IDLE immediately. The `uart_tx` frame in flight is not tracked; the next grant waits for `tx_busy` low.
- Handshake at edge N → `tx_start` high during cycle N+1 only.
- `tx_busy` rise is sampled from cycle N+2 onward.
- `frame_done` is high the cycle after `tx_busy` is sampled low in WAIT_DONE. The earliest next `req_ready` is that same cycle's IDLE, giving back-to-back grants with one idle cycle.
- Simultaneous `req_valid`: exactly one grant per frame, following pointer order.

## Structure
- Package `uart_arb_pkg` holds:
  - state enum `arb_state_e` {IDLE, START, WAIT_BUSY, WAIT_DONE}
  - default `NUM_REQ` and `START_TIMEOUT` constants
- Sub-module `rr_arbiter`: combinational round-robin winner from `req_valid` and `rr_ptr`. Outputs one-hot grant, winner index and `any_valid`.
- Top level holds the FSM, the output registers and the timeout counter. It instantiates alongside `uart_tx` in the bench.

## Test plan
- Single request: `req_valid`=4'b0001, `req_data[0]`=8'hA5, parity on/even → one `tx_start` pulse, `data_in`=8'hA5, and the `uart_tx` serial line carries frame 0,10100101 LSB-first, parity 0, stop 1. `frame_done` pulses once; `grant_id`=0.
- All four valid with bytes 11/22/33/44 → grant order 0,1,2,3, then wrap to 0. `tx_start` never occurs while `tx_busy` is high.
- Pointer at 2, requests from 0 and 3 only → 3 is granted first, then 0.
- `tx_busy` held low by the bench stub after `tx_start` → `timeout_err` pulses 8 cycles after WAIT_BUSY entry, FSM returns to IDLE, and the next requester is granted.
- `rst` asserted during WAIT_DONE → all outputs take reset values asynchronously. After release with `tx_busy` still high, no grant occurs until `tx_busy` falls.
- Parity-off request (`req_parity_en[1]`=0, 8'h0F) → `parity_en`=0 and a 10-bit frame on `tx`; the following parity-on grant restores `parity_en`=1.
